// File: rtl/pkt_buf_mem_arb_if.sv
// Bundle of the two DMA client ports and the packet-buffer memory port.
// The slave side is the arbiter; the master side is the clients plus the memory model.
interface pkt_buf_mem_arb_if #(
    parameter int unsigned DWIDTH = 64,
    parameter int unsigned AWIDTH = 8
);
    logic              c0_wreq;
    logic [AWIDTH-1:0] c0_waddr;
    logic [DWIDTH-1:0] c0_wdata;
    logic              c0_wgnt;
    logic              c0_rreq;
    logic [AWIDTH-1:0] c0_raddr;
    logic              c0_rgnt;
    logic [DWIDTH-1:0] c0_rdata;
    logic              c0_rvalid;

    logic              c1_wreq;
    logic [AWIDTH-1:0] c1_waddr;
    logic [DWIDTH-1:0] c1_wdata;
    logic              c1_wgnt;
    logic              c1_rreq;
    logic [AWIDTH-1:0] c1_raddr;
    logic              c1_rgnt;
    logic [DWIDTH-1:0] c1_rdata;
    logic              c1_rvalid;

    logic              mem_busy;
    logic              mem_en;
    logic              mem_we;
    logic [AWIDTH:0]   mem_addr;
    logic [DWIDTH-1:0] mem_wdata;
    logic [DWIDTH-1:0] mem_rdata;

    logic [3:0]        starve_err;

    modport slave (
        input  c0_wreq, c0_waddr, c0_wdata, c0_rreq, c0_raddr,
        input  c1_wreq, c1_waddr, c1_wdata, c1_rreq, c1_raddr,
        input  mem_busy, mem_rdata,
        output c0_wgnt, c0_rgnt, c0_rdata, c0_rvalid,
        output c1_wgnt, c1_rgnt, c1_rdata, c1_rvalid,
        output mem_en, mem_we, mem_addr, mem_wdata,
        output starve_err
    );

    modport master (
        output c0_wreq, c0_waddr, c0_wdata, c0_rreq, c0_raddr,
        output c1_wreq, c1_waddr, c1_wdata, c1_rreq, c1_raddr,
        output mem_busy, mem_rdata,
        input  c0_wgnt, c0_rgnt, c0_rdata, c0_rvalid,
        input  c1_wgnt, c1_rgnt, c1_rdata, c1_rvalid,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        input  starve_err
    );
endinterface

// File: rtl/pkt_buf_mem_arb.sv
// Round-robin arbiter sharing one single-port packet buffer between two DMA clients
// (write + read source each), with read-data return routing and per-source starvation watchdog.
module pkt_buf_mem_arb #(
    parameter int unsigned DWIDTH   = 64,
    parameter int unsigned AWIDTH   = 8,
    parameter int unsigned MAX_WAIT = 16
) (
    input  logic              clk,
    input  logic              rst,
    pkt_buf_mem_arb_if.slave  bus
);
    localparam int unsigned NSRC = 4;
    localparam int unsigned CW   = $clog2(MAX_WAIT) + 1;
    localparam logic [DWIDTH-1:0] ZERO_D = '0;
    localparam logic [CW-1:0]     WAIT_MAX = CW'(MAX_WAIT);

    logic [NSRC-1:0]   w_req;
    logic [NSRC-1:0]   w_arb;
    logic [NSRC-1:0]   w_gnt;
    logic [1:0]        w_src;
    logic [1:0]        w_idx;
    logic [1:0]        w_ptr_nxt;
    logic [AWIDTH-1:0] w_addr [NSRC];
    logic [CW-1:0]     w_wait_nxt [NSRC];

    logic [1:0]        r_ptr;
    logic              r_tag_vld;
    logic              r_tag_cli;
    logic [CW-1:0]     r_wait [NSRC];
    logic [NSRC-1:0]   r_starve;

    // Source order: 0 c0 write, 1 c0 read, 2 c1 write, 3 c1 read
    assign w_req     = {bus.c1_rreq, bus.c1_wreq, bus.c0_rreq, bus.c0_wreq};
    assign w_addr[0] = bus.c0_waddr;
    assign w_addr[1] = bus.c0_raddr;
    assign w_addr[2] = bus.c1_waddr;
    assign w_addr[3] = bus.c1_raddr;

    // Cyclic first-asserted search starting at r_ptr
    always_comb begin
        w_arb     = '0;
        w_src     = '0;
        w_idx     = '0;
        w_ptr_nxt = r_ptr;
        if (!bus.mem_busy) begin
            for (int i = 0; i < NSRC; i++) begin
                w_idx = 2'(r_ptr + 2'(i));
                if (w_req[w_idx] && (w_arb == '0)) begin
                    w_arb[w_idx] = 1'b1;
                    w_src        = w_idx;
                    w_ptr_nxt    = 2'(w_idx + 2'd1);
                end
            end
        end
    end

    // Outputs are forced low while reset is held; the flops are held in reset anyway
    assign w_gnt = rst ? w_arb : '0;

    assign bus.c0_wgnt = w_gnt[0];
    assign bus.c0_rgnt = w_gnt[1];
    assign bus.c1_wgnt = w_gnt[2];
    assign bus.c1_rgnt = w_gnt[3];

    always_comb begin
        bus.mem_en    = |w_gnt;
        bus.mem_we    = w_gnt[0] | w_gnt[2];
        bus.mem_addr  = '0;
        bus.mem_wdata = ZERO_D;
        if (w_gnt != '0) begin
            bus.mem_addr = {w_src[1], w_addr[w_src]};
        end
        if (w_gnt[0]) begin
            bus.mem_wdata = bus.c0_wdata;
        end else if (w_gnt[2]) begin
            bus.mem_wdata = bus.c1_wdata;
        end
    end

    // Read return: the tag from last cycle's read grant steers mem_rdata
    assign bus.c0_rvalid = r_tag_vld & ~r_tag_cli;
    assign bus.c1_rvalid = r_tag_vld &  r_tag_cli;
    assign bus.c0_rdata  = bus.c0_rvalid ? bus.mem_rdata : ZERO_D;
    assign bus.c1_rdata  = bus.c1_rvalid ? bus.mem_rdata : ZERO_D;
    assign bus.starve_err = r_starve;

    always_comb begin
        for (int i = 0; i < NSRC; i++) begin
            w_wait_nxt[i] = '0;
            if (w_req[i] && !w_arb[i]) begin
                w_wait_nxt[i] = (r_wait[i] == WAIT_MAX) ? WAIT_MAX : CW'(r_wait[i] + CW'(1));
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr     <= '0;
            r_tag_vld <= 1'b0;
            r_tag_cli <= 1'b0;
            r_starve  <= '0;
            for (int i = 0; i < NSRC; i++) begin
                r_wait[i] <= '0;
            end
        end else begin
            r_ptr     <= w_ptr_nxt;
            r_tag_vld <= w_arb[1] | w_arb[3];
            r_tag_cli <= w_arb[3];
            for (int i = 0; i < NSRC; i++) begin
                r_wait[i] <= w_wait_nxt[i];
                if (w_wait_nxt[i] == WAIT_MAX) begin
                    r_starve[i] <= 1'b1;
                end
            end
        end
    end
endmodule
